// File: rtl/alu_uart_if_pkg.sv
// alu_uart_if_pkg -- shared FSM states, ALU op codes and framing helper for the ALU/UART bridge.
// Rev 1.0
`default_nettype none

package alu_uart_if_pkg;

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
    WAIT_RES = 3'd5,
    SEND_FLG = 3'd6,
    WAIT_FLG = 3'd7
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Second response byte: zero in bit 1, overflow in bit 0.
  function automatic logic [7:0] flag_byte(input logic zero, input logic overflow);
    return {6'b0, zero, overflow};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_uart_if_if.sv
// alu_uart_if_if -- UART byte stream and ALU operand/result bundle seen by the bridge.
// Rev 1.0
`default_nettype none

interface alu_uart_if_if #(
  parameter int N    = 8,
  parameter int NSel = 6
);

  logic [7:0]      i_rx_data;
  logic            i_rx_done;
  logic            i_tx_done;
  logic [N-1:0]    i_alu_result;
  logic            i_alu_overflow;
  logic            i_alu_zero;
  logic [N-1:0]    o_alu_A;
  logic [N-1:0]    o_alu_B;
  logic [NSel-1:0] o_alu_Op;
  logic [7:0]      o_tx_data;
  logic            o_tx_start;
  logic            o_busy;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_overflow, i_alu_zero,
    output o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_tx_start, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_overflow, i_alu_zero,
    input  o_alu_A, o_alu_B, o_alu_Op, o_tx_data, o_tx_start, o_busy
  );

endinterface

`default_nettype wire

// File: rtl/alu_uart_if.sv
// alu_uart_if -- collects A, B, op bytes from the UART receiver, runs the ALU and returns result and flag bytes.
// Rev 1.0
`default_nettype none

module alu_uart_if
  import alu_uart_if_pkg::*;
#(
  parameter int N         = 8,
  parameter int NSel      = 6,
  parameter int EXEC_WAIT = 2
) (
  input  wire logic     i_clock,
  input  wire logic     i_reset,
  alu_uart_if_if.master bus
);

  localparam int CW = (EXEC_WAIT < 1) ? 1 : $clog2(EXEC_WAIT + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    alu_a, alu_a_n;
  logic [N-1:0]    alu_b, alu_b_n;
  logic [NSel-1:0] alu_op, alu_op_n;
  logic [N-1:0]    res_hold, res_hold_n;
  logic            ovf_hold, ovf_hold_n;
  logic            zero_hold, zero_hold_n;
  logic [7:0]      tx_data, tx_data_n;
  logic            tx_start, tx_start_n;
  logic            busy, busy_n;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    alu_op_n    = alu_op;
    res_hold_n  = res_hold;
    ovf_hold_n  = ovf_hold;
    zero_hold_n = zero_hold;
    tx_data_n   = tx_data;
    tx_start_n  = 1'b0;

    case (state)
      WAIT_A: begin
        if (bus.i_rx_done) begin
          alu_a_n = N'(bus.i_rx_data);
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.i_rx_done) begin
          alu_b_n = N'(bus.i_rx_data);
          state_n = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (bus.i_rx_done) begin
          alu_op_n = bus.i_rx_data[NSel-1:0];
          cnt_n    = '0;
          state_n  = EXEC;
        end
      end
      // Gives the ALU EXEC_WAIT cycles to settle on the new operands before sampling.
      EXEC: begin
        if (cnt == CW'(EXEC_WAIT)) begin
          res_hold_n  = bus.i_alu_result;
          ovf_hold_n  = bus.i_alu_overflow;
          zero_hold_n = bus.i_alu_zero;
          state_n     = SEND_RES;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SEND_RES: begin
        tx_data_n  = res_hold[7:0];
        tx_start_n = 1'b1;
        state_n    = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.i_tx_done) begin
          state_n = SEND_FLG;
        end
      end
      SEND_FLG: begin
        tx_data_n  = flag_byte(zero_hold, ovf_hold);
        tx_start_n = 1'b1;
        state_n    = WAIT_FLG;
      end
      WAIT_FLG: begin
        if (bus.i_tx_done) begin
          state_n = WAIT_A;
        end
      end
      default: begin
        state_n = WAIT_A;
      end
    endcase

    // Busy is registered from the next state so it lines up with the state register.
    busy_n = (state_n != WAIT_A);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_hold  <= '0;
      ovf_hold  <= 1'b0;
      zero_hold <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      alu_op    <= alu_op_n;
      res_hold  <= res_hold_n;
      ovf_hold  <= ovf_hold_n;
      zero_hold <= zero_hold_n;
      tx_data   <= tx_data_n;
      tx_start  <= tx_start_n;
      busy      <= busy_n;
    end
  end

  assign bus.o_alu_A    = alu_a;
  assign bus.o_alu_B    = alu_b;
  assign bus.o_alu_Op   = alu_op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_busy     = busy;

endmodule

`default_nettype wire

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 Parameter N, default 8, shall set ALU operand/result width; N=8 supported, byte framing assumes N=8.
REQ-002 Parameter NSel, default 6, shall set ALU operation code width.
REQ-003 Parameter EXEC_WAIT, default 2, shall set cycles from operand/op presentation to result sampling.
REQ-004 Clock i_clock and reset i_reset (synchronous, active-high) shall be as already decided.
REQ-005 i_clock  in  1  system clock.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_rx_data  in  8  received byte, valid when i_rx_done=1.
REQ-008 i_rx_done  in  1  one-cycle pulse, byte received.
REQ-009 i_tx_done  in  1  one-cycle pulse, transmitter finished current byte.
REQ-010 i_alu_result  in  N  ALU result.
REQ-011 i_alu_overflow  in  1  ALU overflow flag.
REQ-012 i_alu_zero  in  1  ALU zero flag.
REQ-013 o_alu_A  out  N  operand A to ALU.
REQ-014 o_alu_B  out  N  operand B to ALU.
REQ-015 o_alu_Op  out  NSel  operation code to ALU.
REQ-016 o_tx_data  out  8  byte to transmit.
REQ-017 o_tx_start  out  1  one-cycle pulse, start transmission.
REQ-018 o_busy  out  1  high in every state except WAIT_A.

Function
REQ-019 FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-020 WAIT_A: on i_rx_done, register i_rx_data into o_alu_A, go WAIT_B.
REQ-021 WAIT_B: on i_rx_done, register into o_alu_B, go WAIT_OP.
REQ-022 WAIT_OP: on i_rx_done, register i_rx_data[NSel-1:0] into o_alu_Op (upper bits ignored), clear wait counter, go EXEC.
REQ-023 EXEC: counter increments each cycle; when it reaches EXEC_WAIT, latch i_alu_result, i_alu_overflow, i_alu_zero into holding registers, go SEND_RES.
REQ-024 SEND_RES: o_tx_data = result byte, o_tx_start=1 for exactly one cycle, go WAIT_RES.
REQ-025 WAIT_RES: on i_tx_done, go SEND_FLG.
REQ-026 SEND_FLG: o_tx_data = {6'b0, zero, overflow}, o_tx_start=1 one cycle, go WAIT_FLG.
REQ-027 WAIT_FLG: on i_tx_done, go WAIT_A; o_alu_A/B/Op retain last values.
REQ-028 i_rx_done in EXEC/SEND/WAIT states shall be ignored (byte dropped, no state change).
REQ-029 i_tx_done outside WAIT_RES/WAIT_FLG shall be ignored.
REQ-030 Invalid op codes shall be forwarded unchanged; response is whatever ALU returns.
REQ-031 o_tx_data shall hold its value until the next SEND state.
REQ-032 All outputs shall be registered; no combinational path input-to-output.

Reset
REQ-033 On i_reset: state WAIT_A, counter 0, o_alu_A/B=0, o_alu_Op=0, o_tx_data=0, o_tx_start=0, o_busy=0, holding registers 0.
REQ-034 Reset shall take priority over all events, including mid-frame and mid-transmission; partial frames discarded.

Structure
REQ-035 State encoding and op-code localparams (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111) shall live in a shared package/include used by ALU and this block.
REQ-036 Single module, no sub-module; top-level instantiates it beside the ALU and UART rx/tx.

Verification
REQ-037 Bench ALU model: registered, 1-cycle latency; UART modelled by rx_done/tx_done pulses.
REQ-038 Rx 0x05,0x03,0x20 (ADD) -> o_alu_A=0x05,B=0x03,Op=0x20; tx 0x08 then 0x00.
REQ-039 Rx 0x7F,0x01,0x20 -> tx 0x80 then 0x01 (overflow).
REQ-040 Rx 0x05,0x05,0x22 (SUB) with model zero=1 -> tx 0x00 then 0x02.
REQ-041 Extra rx_done (0xAA) during EXEC/WAIT_RES -> ignored; next frame starts cleanly in WAIT_A.
REQ-042 i_reset after A and B received -> all outputs 0, WAIT_A; next 3 bytes form a fresh frame.
REQ-043 Rx op byte 0xE4 -> o_alu_Op=0x24 (AND), upper bits discarded.
